// File: rtl/ysyx_23060332_mem_arbiter.sv
// ysyx_23060332_mem_arbiter
//   Shares the core's single memory port between instruction fetch (IFU) and
//   the load/store unit (LSU). One transaction in flight; simultaneous
//   requests are broken round-robin on the last granted requester.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   i_ifu_*             fetch request (read-only) / o_ifu_* accept + response
//   i_lsu_*             load/store request        / o_lsu_* accept + response
//   o_mem_*             latched command to memory, o_mem_valid while in REQ
//   i_mem_ready         memory accepts the command
//   i_mem_rvalid/rdata  memory response (acks reads and writes)
//   o_busy              arbiter not idle
//   o_owner             0 = IFU, 1 = LSU; meaningful while busy
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch
    input  logic                i_ifu_valid,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_ready,
    output logic                o_ifu_rvalid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    // load/store unit
    input  logic                i_lsu_valid,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wmask,
    output logic                o_lsu_ready,
    output logic                o_lsu_rvalid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    // memory port
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    // status
    output logic                o_busy,
    output logic                o_owner
);

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_grant_ifu;
    logic                w_grant_lsu;

    logic                r_owner;
    logic                r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;
    logic                r_ifu_rvalid;
    logic                r_lsu_rvalid;
    logic [DATA_W-1:0]   r_ifu_rdata;
    logic [DATA_W-1:0]   r_lsu_rdata;

    // Grant decision depends only on request valids, state and last_grant,
    // so readies never see a combinational path from the memory side.
    // Readies are held low while rst is high so no handshake completes in a
    // cycle whose state update is about to be discarded.
    always_comb begin
        w_next      = r_state;
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    w_grant_ifu = i_ifu_valid && (!i_lsu_valid || r_last_grant == OWN_LSU);
                    w_grant_lsu = i_lsu_valid && (!i_ifu_valid || r_last_grant == OWN_IFU);
                end
                if (w_grant_ifu || w_grant_lsu)
                    w_next = S_REQ;
            end
            S_REQ: begin
                if (i_mem_ready)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_rvalid)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_LSU;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
        end else begin
            r_state      <= w_next;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;

            // Fetches are reads: write fields are forced to zero.
            if (w_grant_ifu) begin
                r_addr       <= i_ifu_addr;
                r_wen        <= 1'b0;
                r_wdata      <= '0;
                r_wmask      <= '0;
                r_owner      <= OWN_IFU;
                r_last_grant <= OWN_IFU;
            end else if (w_grant_lsu) begin
                r_addr       <= i_lsu_addr;
                r_wen        <= i_lsu_wen;
                r_wdata      <= i_lsu_wdata;
                r_wmask      <= i_lsu_wmask;
                r_owner      <= OWN_LSU;
                r_last_grant <= OWN_LSU;
            end

            // Responses are only honoured in WAIT; a stray mem_rvalid in
            // IDLE/REQ (including one arriving after an abort) is dropped.
            if (r_state == S_WAIT && i_mem_rvalid) begin
                if (r_owner == OWN_LSU) begin
                    r_lsu_rdata  <= i_mem_rdata;
                    r_lsu_rvalid <= 1'b1;
                end else begin
                    r_ifu_rdata  <= i_mem_rdata;
                    r_ifu_rvalid <= 1'b1;
                end
            end
        end
    end

    assign o_ifu_ready  = w_grant_ifu;
    assign o_lsu_ready  = w_grant_lsu;
    assign o_ifu_rvalid = r_ifu_rvalid;
    assign o_lsu_rvalid = r_lsu_rvalid;
    assign o_ifu_rdata  = r_ifu_rdata;
    assign o_lsu_rdata  = r_lsu_rdata;

    assign o_mem_valid  = (r_state == S_REQ);
    assign o_mem_addr   = r_addr;
    assign o_mem_wen    = r_wen;
    assign o_mem_wdata  = r_wdata;
    assign o_mem_wmask  = r_wmask;

    assign o_busy       = (r_state != S_IDLE);
    assign o_owner      = r_owner;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Self-checking bench for ysyx_23060332_mem_arbiter: a table of request
// patterns with hand-computed grants/commands/responses, then hand-written
// sequences for reset mid-transaction and back-to-back fetches.
module tb_ysyx_23060332_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ifu_valid = 1'b0;
    logic [31:0] i_ifu_addr = '0;
    logic        o_ifu_ready, o_ifu_rvalid;
    logic [31:0] o_ifu_rdata;
    logic        i_lsu_valid = 1'b0;
    logic [31:0] i_lsu_addr = '0;
    logic        i_lsu_wen = 1'b0;
    logic [31:0] i_lsu_wdata = '0;
    logic [3:0]  i_lsu_wmask = '0;
    logic        o_lsu_ready, o_lsu_rvalid;
    logic [31:0] o_lsu_rdata;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_busy, o_owner;

    ysyx_23060332_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_ifu_valid(i_ifu_valid), .i_ifu_addr(i_ifu_addr),
        .o_ifu_ready(o_ifu_ready), .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
        .i_lsu_valid(i_lsu_valid), .i_lsu_addr(i_lsu_addr), .i_lsu_wen(i_lsu_wen),
        .i_lsu_wdata(i_lsu_wdata), .i_lsu_wmask(i_lsu_wmask),
        .o_lsu_ready(o_lsu_ready), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          rv_cyc = 0;
    logic        allow_stray = 1'b0;
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants on the handshake outputs.
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl_ready",  {63'd0, o_ifu_ready & o_lsu_ready}, 64'd0);
            chk("ready_idle",  {63'd0, (o_ifu_ready | o_lsu_ready) & o_busy}, 64'd0);
            chk("excl_rvalid", {63'd0, o_ifu_rvalid & o_lsu_rvalid}, 64'd0);
        end
    end

    // mem_rvalid outside WAIT (busy and not presenting a command) is a
    // protocol error of the memory model.
    always @(posedge clk) begin
        if (!rst && !allow_stray)
            assert (!(i_mem_rvalid && !(o_busy && !o_mem_valid)))
                else $error("protocol: stray mem_rvalid");
    end

    // Called in the accept cycle (ready already checked). Runs REQ/WAIT with
    // the given memory delays and returns in the cycle carrying the rvalid.
    task automatic do_xfer(input logic own, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] rdata, input int rdly, input int vdly);
        step();
        i_ifu_valid = 1'b0;
        i_lsu_valid = 1'b0;
        for (int k = 0; k <= rdly; k++) begin
            i_mem_ready = (k == rdly);
            #1;
            chk("req_valid", o_mem_valid, 1'b1);
            chk("req_addr",  o_mem_addr, addr);
            chk("req_wen",   o_mem_wen, wen);
            chk("req_wdata", o_mem_wdata, wdata);
            chk("req_wmask", o_mem_wmask, wmask);
            chk("req_owner", {o_busy, o_owner}, {1'b1, own});
            chk("req_rvld",  {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
            step();
        end
        i_mem_ready = 1'b0;
        for (int k = 0; k <= vdly; k++) begin
            i_mem_rvalid = (k == vdly);
            i_mem_rdata  = (k == vdly) ? rdata : 32'hFFFF_FFFF;
            #1;
            chk("wait_mvalid", o_mem_valid, 1'b0);
            chk("wait_busy",   o_busy, 1'b1);
            chk("wait_rvld",   {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
            step();
        end
        i_mem_rvalid = 1'b0;
        exp_rd[own] = rdata;
        chk("rsp_rvld",  {o_ifu_rvalid, o_lsu_rvalid}, {~own, own});
        chk("rsp_ifu_rdata", o_ifu_rdata, exp_rd[0]);
        chk("rsp_lsu_rdata", o_lsu_rdata, exp_rd[1]);
        chk("rsp_idle",  {o_busy, o_mem_valid}, 2'b00);
        rv_cyc = cyc;
    endtask

    typedef struct {
        logic        iv, lv, wen, er_i, er_l;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wmask;
        int          rdly, vdly;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // iv lv wen | exp ifu_rdy lsu_rdy | addr (lsu uses +0x1000) wdata rdata wmask | delays
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h0,        32'h0,        4'h0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'hAAAA5555, 32'h00100093, 4'h3, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000100, 32'h11112222, 32'hCAFEF00D, 4'hF, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80000008, 32'h0,        32'h00000013, 4'h0, 1, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'hDEADBEEF, 32'h0,        4'hF, 3, 0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000200, 32'h0,        32'h5A5A5A5A, 4'hF, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000010, 32'h0,        32'h12345678, 4'h0, 0, 5};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80000300, 32'h01020304, 32'h0,        4'h6, 0, 0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h0,        32'h0,        4'h0, 0, 0};

        // Reset values
        rst = 1'b1;
        step();
        step();
        chk("rst_ready",  {o_ifu_ready, o_lsu_ready}, 2'b00);
        chk("rst_rvalid", {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
        chk("rst_rdata",  {o_ifu_rdata, o_lsu_rdata}, 64'd0);
        chk("rst_cmd",    {o_mem_valid, o_mem_wen, o_mem_wmask, o_mem_addr}, 38'd0);
        chk("rst_wdata",  o_mem_wdata, 32'd0);
        chk("rst_status", {o_busy, o_owner}, 2'b00);
        rst = 1'b0;

        // Table: grants, latched command, response routing
        for (int i = 0; i < 9; i++) begin
            i_ifu_valid = vecs[i].iv;
            i_lsu_valid = vecs[i].lv;
            i_ifu_addr  = vecs[i].addr;
            i_lsu_addr  = vecs[i].addr + 32'h1000;
            i_lsu_wen   = vecs[i].wen;
            i_lsu_wdata = vecs[i].wdata;
            i_lsu_wmask = vecs[i].wmask;
            #1;
            chk($sformatf("v%0d_ready", i), {o_ifu_ready, o_lsu_ready},
                {vecs[i].er_i, vecs[i].er_l});
            if (vecs[i].er_i)
                do_xfer(1'b0, vecs[i].addr, 1'b0, 32'h0, 4'h0,
                        vecs[i].rdata, vecs[i].rdly, vecs[i].vdly);
            else if (vecs[i].er_l)
                do_xfer(1'b1, vecs[i].addr + 32'h1000, vecs[i].wen, vecs[i].wdata,
                        vecs[i].wmask, vecs[i].rdata, vecs[i].rdly, vecs[i].vdly);
            else begin
                step();
                chk($sformatf("v%0d_idle", i), {o_busy, o_ifu_rvalid, o_lsu_rvalid}, 3'b000);
            end
        end

        // Reset mid-WAIT with LSU as owner
        i_lsu_valid = 1'b1;
        i_lsu_addr  = 32'h80002000;
        i_lsu_wen   = 1'b0;
        #1;
        chk("abort_lsu_ready", {o_ifu_ready, o_lsu_ready}, 2'b01);
        step();
        i_lsu_valid = 1'b0;
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        chk("abort_in_wait", {o_busy, o_mem_valid, o_owner}, 3'b101);
        rst = 1'b1;
        step();
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        chk("abort_status", {o_busy, o_owner, o_mem_valid}, 3'b000);
        chk("abort_rvalid", {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
        chk("abort_rdata",  {o_ifu_rdata, o_lsu_rdata}, 64'd0);
        chk("abort_cmd",    {o_mem_wen, o_mem_wmask, o_mem_addr}, 37'd0);
        rst = 1'b0;
        allow_stray  = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0BAD0;
        step();
        i_mem_rvalid = 1'b0;
        allow_stray  = 1'b0;
        chk("late_rvalid", {o_busy, o_lsu_rvalid, o_ifu_rvalid}, 3'b000);
        chk("late_rdata",  o_lsu_rdata, 32'd0);
        i_ifu_valid = 1'b1;
        i_lsu_valid = 1'b1;
        i_ifu_addr  = 32'h80000400;
        i_lsu_addr  = 32'h80003000;
        #1;
        chk("abort_tie_ifu", {o_ifu_ready, o_lsu_ready}, 2'b10);
        do_xfer(1'b0, 32'h80000400, 1'b0, 32'h0, 4'h0, 32'h00000073, 0, 0);

        // Back-to-back fetches: next accept overlaps the previous response
        i_ifu_valid = 1'b1;
        i_ifu_addr  = 32'h80000000;
        #1;
        chk("b2b_ready0", {o_ifu_ready, o_lsu_ready}, 2'b10);
        do_xfer(1'b0, 32'h80000000, 1'b0, 32'h0, 4'h0, 32'h00100093, 0, 0);
        begin
            int first_rv;
            first_rv = rv_cyc;
            i_ifu_valid = 1'b1;
            i_ifu_addr  = 32'h80000004;
            #1;
            chk("b2b_ready1_with_rvalid", {o_ifu_ready, o_ifu_rvalid}, 2'b11);
            do_xfer(1'b0, 32'h80000004, 1'b0, 32'h0, 4'h0, 32'h00200113, 0, 0);
            chk("b2b_period", rv_cyc - first_rv, 64'd3);
        end
        step();
        chk("final_quiet", {o_busy, o_ifu_rvalid, o_lsu_rvalid}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
